// File: rtl/uart_pkg.sv
// Shared DMI-over-UART constants, length lookups and host FSM state types.
// Exports IRLENGTH, CMDLENGTH, CMD_*, ADDR_*, get_write/read_length, host_*_state_t.
package uart_pkg;

  localparam int IRLENGTH  = 5;
  localparam int CMDLENGTH = 3;
  localparam int ABITS     = 7;

  localparam logic [CMDLENGTH-1:0] CMD_READ      = 3'd1;
  localparam logic [CMDLENGTH-1:0] CMD_CONT_READ = 3'd2;
  localparam logic [CMDLENGTH-1:0] CMD_WRITE     = 3'd3;
  localparam logic [CMDLENGTH-1:0] CMD_RESET     = 3'd4;

  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_DTMCS  = 5'h10;
  localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;
  localparam logic [IRLENGTH-1:0] ADDR_BYPASS = 5'h1f;

  function automatic int get_write_length(
    input logic [IRLENGTH-1:0] addr
  );
    case (addr)
      ADDR_DMI:   return ABITS + 34;
      ADDR_DTMCS: return 32;
      default:    return 0;
    endcase
  endfunction

  function automatic int get_read_length(
    input logic [IRLENGTH-1:0] addr
  );
    case (addr)
      ADDR_DMI:    return ABITS + 34;
      ADDR_DTMCS:  return 32;
      ADDR_IDCODE: return 32;
      default:     return 0;
    endcase
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_CMD,
    TX_DATA
  } host_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_RESP
  } host_rx_state_t;

endpackage

// File: rtl/dmi_uart_host_rx.sv
// RX side: pops TAP bytes, assembles LSB-first frames per rx_addr, presents responses.
// Ports: CLK_I/RST_NI, RX FIFO head (RX_EMPTY_I, DATA_REC_I, CMD_REC_I, READ_O), RSP_*.
// Optional DMI_UART_HOST_TIMEOUT_EN discards stalled partial frames.
module dmi_uart_host_rx
  import uart_pkg::*;
#(
  parameter int WIDTH          = 41,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                CLK_I,
  input  logic                RST_NI,
  input  logic                RX_EMPTY_I,
  input  logic [7:0]          DATA_REC_I,
  input  logic                CMD_REC_I,
  output logic                READ_O,
  output logic                RSP_VALID_O,
  input  logic                RSP_READY_I,
  output logic [IRLENGTH-1:0] RSP_ADDR_O,
  output logic [WIDTH-1:0]    RSP_DATA_O,
  output logic                RSP_TIMEOUT_O
);

  localparam int MAX_BYTES = (WIDTH + 7) / 8;
  localparam int BW        = MAX_BYTES * 8;
  localparam int CW        = $clog2(MAX_BYTES + 1);

  function automatic logic [BW-1:0] len_mask(input int len);
    logic [BW-1:0] m;
    for (int i = 0; i < BW; i++) m[i] = (i < len);
    return m;
  endfunction

  host_rx_state_t      st;
  logic [IRLENGTH-1:0] rx_addr;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       pop_idx;
  logic [CW-1:0]       rd_nb;
  logic [BW-1:0]       frame_q;
  logic [BW-1:0]       frame_d;
  logic [BW-1:0]       rd_mask;

  assign READ_O  = RST_NI && !RX_EMPTY_I && (st != RX_RESP);
  assign rd_nb   = CW'((get_read_length(rx_addr) + 7) / 8);
  assign rd_mask = len_mask(get_read_length(rx_addr));
  assign pop_idx = (st == RX_DATA) ? cnt : '0;

  always_comb begin
    frame_d = (st == RX_DATA) ? frame_q : '0;
    frame_d[{pop_idx, 3'b000} +: 8] = DATA_REC_I;
  end

`ifdef DMI_UART_HOST_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;
  assign to_hit = (st == RX_DATA) && !READ_O
               && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  logic          to_hit;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      st          <= RX_IDLE;
      rx_addr     <= ADDR_IDCODE;
      cnt         <= '0;
      frame_q     <= '0;
      RSP_VALID_O <= 1'b0;
      RSP_ADDR_O  <= ADDR_IDCODE;
      RSP_DATA_O  <= '0;
    end else if (READ_O) begin
      if (CMD_REC_I) begin
        // Address notification restarts framing
        rx_addr <= DATA_REC_I[IRLENGTH-1:0];
        st      <= RX_IDLE;
        cnt     <= '0;
        frame_q <= '0;
      end else if (rd_nb == '0) begin
        st <= RX_IDLE;
      end else if (pop_idx == rd_nb - CW'(1)) begin
        st          <= RX_RESP;
        RSP_VALID_O <= 1'b1;
        RSP_ADDR_O  <= rx_addr;
        RSP_DATA_O  <= WIDTH'(frame_d & rd_mask);
        frame_q     <= '0;
        cnt         <= '0;
      end else begin
        st      <= RX_DATA;
        frame_q <= frame_d;
        cnt     <= pop_idx + CW'(1);
      end
    end else if (to_hit) begin
      st      <= RX_IDLE;
      frame_q <= '0;
      cnt     <= '0;
    end else if (st == RX_RESP && RSP_READY_I) begin
      st          <= RX_IDLE;
      RSP_VALID_O <= 1'b0;
    end
  end

`ifdef DMI_UART_HOST_TIMEOUT_EN
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      to_cnt        <= '0;
      RSP_TIMEOUT_O <= 1'b0;
    end else begin
      RSP_TIMEOUT_O <= to_hit;
      if (st != RX_DATA || READ_O || to_hit) to_cnt <= '0;
      else to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  assign RSP_TIMEOUT_O = 1'b0;
`endif

endmodule

// File: rtl/dmi_uart_host.sv
// Host UART initiator: TX FSM serialises requests, RX sub-block decodes responses.
// Ports: CLK_I/RST_NI, REQ_*, UART TX (TX_READY_I, WRITE_O, DATA_SEND_O, SEND_COMMAND_O),
// UART RX (RX_EMPTY_I, DATA_REC_I, CMD_REC_I, READ_O), RSP_*. Option: DMI_UART_HOST_TIMEOUT_EN.
module dmi_uart_host
  import uart_pkg::*;
#(
  parameter int WIDTH          = get_write_length(ADDR_DMI),
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 REQ_VALID_I,
  output logic                 REQ_READY_O,
  input  logic [CMDLENGTH-1:0] REQ_CMD_I,
  input  logic [IRLENGTH-1:0]  REQ_ADDR_I,
  input  logic [WIDTH-1:0]     REQ_DATA_I,
  input  logic                 TX_READY_I,
  output logic                 WRITE_O,
  output logic [7:0]           DATA_SEND_O,
  output logic                 SEND_COMMAND_O,
  input  logic                 RX_EMPTY_I,
  input  logic [7:0]           DATA_REC_I,
  input  logic                 CMD_REC_I,
  output logic                 READ_O,
  output logic                 RSP_VALID_O,
  input  logic                 RSP_READY_I,
  output logic [IRLENGTH-1:0]  RSP_ADDR_O,
  output logic [WIDTH-1:0]     RSP_DATA_O,
  output logic                 RSP_TIMEOUT_O
);

  localparam int MAX_BYTES = (WIDTH + 7) / 8;
  localparam int BW        = MAX_BYTES * 8;
  localparam int CW        = $clog2(MAX_BYTES + 1);

  function automatic logic [BW-1:0] len_mask(input int len);
    logic [BW-1:0] m;
    for (int i = 0; i < BW; i++) m[i] = (i < len);
    return m;
  endfunction

  host_tx_state_t       tx_state;
  logic [CMDLENGTH-1:0] cmd_q;
  logic [IRLENGTH-1:0]  addr_q;
  logic [BW-1:0]        data_q;
  logic [CW-1:0]        nbytes;
  logic [CW-1:0]        idx;
  logic                 fire;

  // A strobe never follows a strobe, giving one idle cycle per byte
  assign fire = TX_READY_I && !WRITE_O;

  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      tx_state       <= TX_IDLE;
      REQ_READY_O    <= 1'b0;
      WRITE_O        <= 1'b0;
      DATA_SEND_O    <= '0;
      SEND_COMMAND_O <= 1'b0;
      cmd_q          <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      nbytes         <= '0;
      idx            <= '0;
    end else begin
      WRITE_O <= 1'b0;
      unique case (tx_state)
        TX_IDLE: begin
          REQ_READY_O <= 1'b1;
          if (REQ_VALID_I && REQ_READY_O) begin
            REQ_READY_O <= 1'b0;
            cmd_q       <= REQ_CMD_I;
            addr_q      <= REQ_ADDR_I;
            data_q      <= BW'(REQ_DATA_I)
                         & len_mask(get_write_length(REQ_ADDR_I));
            nbytes      <= CW'((get_write_length(REQ_ADDR_I) + 7) / 8);
            tx_state    <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (fire) begin
            WRITE_O        <= 1'b1;
            DATA_SEND_O    <= {cmd_q, addr_q};
            SEND_COMMAND_O <= 1'b1;
            idx            <= '0;
            if (cmd_q == CMD_WRITE && nbytes != '0) begin
              tx_state <= TX_DATA;
            end else begin
              tx_state    <= TX_IDLE;
              REQ_READY_O <= 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (fire) begin
            WRITE_O        <= 1'b1;
            DATA_SEND_O    <= data_q[{idx, 3'b000} +: 8];
            SEND_COMMAND_O <= 1'b0;
            idx            <= idx + CW'(1);
            if (idx == nbytes - CW'(1)) begin
              tx_state    <= TX_IDLE;
              REQ_READY_O <= 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  dmi_uart_host_rx #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .CLK_I         (CLK_I),
    .RST_NI        (RST_NI),
    .RX_EMPTY_I    (RX_EMPTY_I),
    .DATA_REC_I    (DATA_REC_I),
    .CMD_REC_I     (CMD_REC_I),
    .READ_O        (READ_O),
    .RSP_VALID_O   (RSP_VALID_O),
    .RSP_READY_I   (RSP_READY_I),
    .RSP_ADDR_O    (RSP_ADDR_O),
    .RSP_DATA_O    (RSP_DATA_O),
    .RSP_TIMEOUT_O (RSP_TIMEOUT_O)
  );

endmodule

// File: tb/tb_dmi_uart_host.sv
// Scoreboard bench for dmi_uart_host: TX byte stream and RX response words.
// Expected bytes/responses are queued at stimulus time and popped by monitors.
module tb_dmi_uart_host;
  import uart_pkg::*;

  localparam int W = 41;

  logic                 clk = 1'b0;
  logic                 RST_NI;
  logic                 REQ_VALID_I;
  logic                 REQ_READY_O;
  logic [CMDLENGTH-1:0] REQ_CMD_I;
  logic [IRLENGTH-1:0]  REQ_ADDR_I;
  logic [W-1:0]         REQ_DATA_I;
  logic                 TX_READY_I;
  logic                 WRITE_O;
  logic [7:0]           DATA_SEND_O;
  logic                 SEND_COMMAND_O;
  logic                 RX_EMPTY_I;
  logic [7:0]           DATA_REC_I;
  logic                 CMD_REC_I;
  logic                 READ_O;
  logic                 RSP_VALID_O;
  logic                 RSP_READY_I;
  logic [IRLENGTH-1:0]  RSP_ADDR_O;
  logic [W-1:0]         RSP_DATA_O;
  logic                 RSP_TIMEOUT_O;

  always #5 clk = ~clk;

  dmi_uart_host #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .CLK_I(clk), .RST_NI(RST_NI),
    .REQ_VALID_I(REQ_VALID_I), .REQ_READY_O(REQ_READY_O),
    .REQ_CMD_I(REQ_CMD_I), .REQ_ADDR_I(REQ_ADDR_I),
    .REQ_DATA_I(REQ_DATA_I), .TX_READY_I(TX_READY_I),
    .WRITE_O(WRITE_O), .DATA_SEND_O(DATA_SEND_O),
    .SEND_COMMAND_O(SEND_COMMAND_O), .RX_EMPTY_I(RX_EMPTY_I),
    .DATA_REC_I(DATA_REC_I), .CMD_REC_I(CMD_REC_I),
    .READ_O(READ_O), .RSP_VALID_O(RSP_VALID_O),
    .RSP_READY_I(RSP_READY_I), .RSP_ADDR_O(RSP_ADDR_O),
    .RSP_DATA_O(RSP_DATA_O), .RSP_TIMEOUT_O(RSP_TIMEOUT_O)
  );

  typedef struct {
    logic [IRLENGTH-1:0] a;
    logic [W-1:0]        d;
  } rsp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_wr = -1;
  bit   gap_on = 1'b0;
  logic [8:0] tx_exp[$];
  rsp_t       rsp_exp[$];
  logic [8:0] rx_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TX monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (WRITE_O) begin
      if (tx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h expected none",
                 {SEND_COMMAND_O, DATA_SEND_O});
      end else begin
        e = tx_exp.pop_front();
        chk("tx_byte", {55'd0, SEND_COMMAND_O, DATA_SEND_O}, {55'd0, e});
      end
      if (gap_on && last_wr >= 0) chk("tx_gap", 64'(cyc - last_wr), 64'd2);
      last_wr = cyc;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (RSP_VALID_O && RSP_READY_I) begin
      if (rsp_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h/%h expected none",
                 RSP_ADDR_O, RSP_DATA_O);
      end else begin
        e = rsp_exp.pop_front();
        chk("rsp_addr", 64'(RSP_ADDR_O), 64'(e.a));
        chk("rsp_data", 64'(RSP_DATA_O), 64'(e.d));
      end
    end
  end

  task rx_refresh();
    RX_EMPTY_I = (rx_q.size() == 0);
    {CMD_REC_I, DATA_REC_I} = (rx_q.size() != 0) ? rx_q[0] : 9'h0;
  endtask

  // RX FIFO model
  always @(posedge clk) begin
    bit rd;
    rd = READ_O;
    #1;
    if (rd && rx_q.size() > 0) rx_q.delete(0);
    rx_refresh();
  end

  task automatic rx_push(input logic c, input logic [7:0] b);
    rx_q.push_back({c, b});
    rx_refresh();
  endtask

  task automatic exp_rsp(input logic [IRLENGTH-1:0] a, input logic [W-1:0] d);
    rsp_t r;
    r.a = a;
    r.d = d;
    rsp_exp.push_back(r);
  endtask

  task automatic send_req(input logic [CMDLENGTH-1:0] c,
                          input logic [IRLENGTH-1:0] a,
                          input logic [W-1:0] d);
    @(negedge clk);
    REQ_CMD_I   = c;
    REQ_ADDR_I  = a;
    REQ_DATA_I  = d;
    REQ_VALID_I = 1'b1;
    last_wr     = -1;
    for (int i = 0; i < 100; i++) begin
      if (REQ_READY_O) break;
      @(negedge clk);
    end
    chk("req_accept", 64'(REQ_READY_O), 64'd1);
    @(posedge clk);
    #1 REQ_VALID_I = 1'b0;
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (tx_exp.size() == 0) break;
    end
    chk("tx_drain", 64'(tx_exp.size()), 64'd0);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (rsp_exp.size() == 0 && rx_q.size() == 0) break;
    end
    chk("rsp_drain", 64'(rsp_exp.size() + rx_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   seen_rd;
    bit   seen_vld;
    int   pulses;
    logic [W-1:0] held;

    RST_NI      = 1'b0;
    REQ_VALID_I = 1'b0;
    REQ_CMD_I   = '0;
    REQ_ADDR_I  = '0;
    REQ_DATA_I  = '0;
    TX_READY_I  = 1'b1;
    RSP_READY_I = 1'b1;
    rx_refresh();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(REQ_READY_O), 64'd0);
    chk("rst_write", 64'(WRITE_O), 64'd0);
    chk("rst_send_cmd", 64'(SEND_COMMAND_O), 64'd0);
    chk("rst_data_send", 64'(DATA_SEND_O), 64'd0);
    chk("rst_read", 64'(READ_O), 64'd0);
    chk("rst_rsp_valid", 64'(RSP_VALID_O), 64'd0);
    chk("rst_rsp_timeout", 64'(RSP_TIMEOUT_O), 64'd0);
    chk("rst_rsp_data", 64'(RSP_DATA_O), 64'd0);
    chk("rst_rsp_addr", 64'(RSP_ADDR_O), 64'(ADDR_IDCODE));
    RST_NI = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(REQ_READY_O), 64'd1);

    // DMI write, 41 bits in 6 bytes, one idle cycle between strobes
    gap_on = 1'b1;
    tx_exp.push_back({1'b1, CMD_WRITE, ADDR_DMI});
    tx_exp.push_back(9'h0AB);
    tx_exp.push_back(9'h089);
    tx_exp.push_back(9'h067);
    tx_exp.push_back(9'h045);
    tx_exp.push_back(9'h023);
    tx_exp.push_back(9'h001);
    send_req(CMD_WRITE, ADDR_DMI, 41'h1_2345_6789_AB);
    wait_tx();
    gap_on = 1'b0;

    // DTMCS write, 4 bytes
    tx_exp.push_back({1'b1, CMD_WRITE, ADDR_DTMCS});
    tx_exp.push_back(9'h00D);
    tx_exp.push_back(9'h0F0);
    tx_exp.push_back(9'h0FE);
    tx_exp.push_back(9'h0CA);
    send_req(CMD_WRITE, ADDR_DTMCS, 41'h1_CAFE_F00D);
    wait_tx();

    // write to a zero-length address, and a reset command: command byte only
    tx_exp.push_back({1'b1, CMD_WRITE, ADDR_IDCODE});
    send_req(CMD_WRITE, ADDR_IDCODE, 41'h0_1234_5678);
    wait_tx();
    tx_exp.push_back({1'b1, CMD_RESET, ADDR_DMI});
    send_req(CMD_RESET, ADDR_DMI, 41'h0);
    wait_tx();

    // IDCODE read
    tx_exp.push_back({1'b1, CMD_READ, ADDR_IDCODE});
    send_req(CMD_READ, ADDR_IDCODE, 41'h0);
    wait_tx();
    exp_rsp(ADDR_IDCODE, 41'h0_1000_0001);
    @(negedge clk);
    rx_push(1'b1, {3'b000, ADDR_IDCODE});
    rx_push(1'b0, 8'h01);
    rx_push(1'b0, 8'h00);
    rx_push(1'b0, 8'h00);
    rx_push(1'b0, 8'h10);
    wait_rsp();

    // continuous read with back-pressure
    tx_exp.push_back({1'b1, CMD_CONT_READ, ADDR_IDCODE});
    send_req(CMD_CONT_READ, ADDR_IDCODE, 41'h0);
    wait_tx();
    @(posedge clk);
    #1 RSP_READY_I = 1'b0;
    exp_rsp(ADDR_IDCODE, 41'h0_1000_0001);
    exp_rsp(ADDR_IDCODE, 41'h0_1234_5678);
    @(negedge clk);
    rx_push(1'b0, 8'h01);
    rx_push(1'b0, 8'h00);
    rx_push(1'b0, 8'h00);
    rx_push(1'b0, 8'h10);
    rx_push(1'b0, 8'h78);
    rx_push(1'b0, 8'h56);
    rx_push(1'b0, 8'h34);
    rx_push(1'b0, 8'h12);
    for (int i = 0; i < 100; i++) begin
      if (RSP_VALID_O) break;
      @(negedge clk);
    end
    chk("bp_valid", 64'(RSP_VALID_O), 64'd1);
    seen_rd = 1'b0;
    held = RSP_DATA_O;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (READ_O) seen_rd = 1'b1;
      if (RSP_DATA_O !== held || !RSP_VALID_O) seen_rd = 1'b1;
    end
    chk("bp_no_read", 64'(seen_rd), 64'd0);
    chk("bp_data_held", 64'(RSP_DATA_O), 64'h1000_0001);
    chk("bp_rx_left", 64'(rx_q.size()), 64'd4);
    @(posedge clk);
    #1 RSP_READY_I = 1'b1;
    wait_rsp();

    // abort: partial IDCODE frame then DTMCS notification
    exp_rsp(ADDR_DTMCS, 41'h0_DEAD_BEEF);
    @(negedge clk);
    rx_push(1'b0, 8'hAA);
    rx_push(1'b0, 8'hBB);
    rx_push(1'b1, {3'b000, ADDR_DTMCS});
    rx_push(1'b0, 8'hEF);
    rx_push(1'b0, 8'hBE);
    rx_push(1'b0, 8'hAD);
    rx_push(1'b0, 8'hDE);
    wait_rsp();

    // DMI read: bits above 41 in the last byte are dropped
    exp_rsp(ADDR_DMI, 41'h1_5544_3322_11);
    @(negedge clk);
    rx_push(1'b1, {3'b000, ADDR_DMI});
    rx_push(1'b0, 8'h11);
    rx_push(1'b0, 8'h22);
    rx_push(1'b0, 8'h33);
    rx_push(1'b0, 8'h44);
    rx_push(1'b0, 8'h55);
    rx_push(1'b0, 8'hFF);
    wait_rsp();

    // zero read length: data dropped
    exp_rsp(ADDR_IDCODE, 41'h0_1234_5678);
    @(negedge clk);
    rx_push(1'b1, {3'b000, ADDR_BYPASS});
    rx_push(1'b0, 8'h12);
    rx_push(1'b0, 8'h34);
    rx_push(1'b1, {3'b000, ADDR_IDCODE});
    rx_push(1'b0, 8'h78);
    rx_push(1'b0, 8'h56);
    rx_push(1'b0, 8'h34);
    rx_push(1'b0, 8'h12);
    wait_rsp();

`ifdef DMI_UART_HOST_TIMEOUT_EN
    pulses = 0;
    seen_vld = 1'b0;
    @(negedge clk);
    rx_push(1'b0, 8'h55);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (RSP_TIMEOUT_O) pulses++;
      if (RSP_VALID_O) seen_vld = 1'b1;
    end
    chk("to_pulses", 64'(pulses), 64'd1);
    chk("to_no_valid", 64'(seen_vld), 64'd0);
    exp_rsp(ADDR_IDCODE, 41'h0_0403_0201);
    rx_push(1'b0, 8'h01);
    rx_push(1'b0, 8'h02);
    rx_push(1'b0, 8'h03);
    rx_push(1'b0, 8'h04);
    wait_rsp();
`endif

    // reset during DMI write
    tx_exp.push_back({1'b1, CMD_WRITE, ADDR_DMI});
    tx_exp.push_back(9'h0AB);
    tx_exp.push_back(9'h089);
    tx_exp.push_back(9'h067);
    send_req(CMD_WRITE, ADDR_DMI, 41'h1_2345_6789_AB);
    wait_tx();
    #1 RST_NI = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_write", 64'(WRITE_O), 64'd0);
    chk("midrst_ready", 64'(REQ_READY_O), 64'd0);
    RST_NI = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", 64'(REQ_READY_O), 64'd1);
    chk("midrst_rsp_addr", 64'(RSP_ADDR_O), 64'(ADDR_IDCODE));
    repeat (20) @(negedge clk);
    chk("end_rsp_left", 64'(rsp_exp.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
